// File: rtl/programmable_blinker_multi.sv
// rtl/programmable_blinker_multi.sv - programmable-rate multi-light rear blinker (off/blink/chase/steady)
// Optional BLINKER_SYNC_EN: 2-flop synchronizers on up_button, down_button and mode.
module programmable_blinker_multi #(
    parameter int LEVELS     = 4,
    parameter int BASE_TICKS = 4,
    parameter int CNT_W      = 16,
    parameter int N_LIGHTS   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                up_button,
    input  logic                down_button,
    input  logic [1:0]          mode,
    output logic [LEVELS-1:0]   rate_level,
    output logic                tick,
    output logic [N_LIGHTS-1:0] rear_light
);
    localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam logic [LW-1:0] L_MAX = LW'(LEVELS - 1);
    localparam logic [1:0] M_OFF    = 2'b00;
    localparam logic [1:0] M_BLINK  = 2'b01;
    localparam logic [1:0] M_CHASE  = 2'b10;
    localparam logic [1:0] M_STEADY = 2'b11;

    logic                w_up;
    logic                w_dn;
    logic [1:0]          w_mode;
    logic                r_up_q;
    logic                r_dn_q;
    logic [LW-1:0]       r_lvl;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_tick;
    logic                r_phase;
    logic [N_LIGHTS-1:0] r_chase;
    logic [1:0]          r_mode_q;
    logic                w_up_e;
    logic                w_dn_e;
    logic [LW-1:0]       w_lvl_next;
    logic                w_reload;
    logic                w_fire;

`ifdef BLINKER_SYNC_EN
    logic [1:0] r_up_s;
    logic [1:0] r_dn_s;
    logic [1:0] r_mode_s1;
    logic [1:0] r_mode_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_up_s    <= 2'b11;
            r_dn_s    <= 2'b11;
            r_mode_s1 <= 2'b00;
            r_mode_s2 <= 2'b00;
        end else begin
            r_up_s    <= {r_up_s[0], up_button};
            r_dn_s    <= {r_dn_s[0], down_button};
            r_mode_s1 <= mode;
            r_mode_s2 <= r_mode_s1;
        end
    end

    assign w_up   = r_up_s[1];
    assign w_dn   = r_dn_s[1];
    assign w_mode = r_mode_s2;
`else
    assign w_up   = up_button;
    assign w_dn   = down_button;
    assign w_mode = mode;
`endif

    // Reload value for a level: half period minus one, slowest at level 0.
    function automatic logic [CNT_W-1:0] hp_m1(input logic [LW-1:0] l);
        return (CNT_W'(BASE_TICKS) << (L_MAX - l)) - CNT_W'(1);
    endfunction

    assign w_up_e = w_up & ~r_up_q;
    assign w_dn_e = w_dn & ~r_dn_q;

    always_comb begin
        w_lvl_next = r_lvl;
        if (w_up_e && !w_dn_e && (r_lvl != L_MAX)) begin
            w_lvl_next = r_lvl + LW'(1);
        end else if (w_dn_e && !w_up_e && (r_lvl != '0)) begin
            w_lvl_next = r_lvl - LW'(1);
        end
    end

    // A real level change or a mode change restarts the timer and swallows the tick.
    assign w_reload = (w_lvl_next != r_lvl) || (w_mode != r_mode_q);
    assign w_fire   = !w_reload && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_up_q   <= 1'b1;
            r_dn_q   <= 1'b1;
            r_lvl    <= '0;
            r_cnt    <= hp_m1('0);
            r_tick   <= 1'b0;
            r_phase  <= 1'b1;
            r_chase  <= N_LIGHTS'(1);
            r_mode_q <= M_OFF;
        end else begin
            r_up_q   <= w_up;
            r_dn_q   <= w_dn;
            r_lvl    <= w_lvl_next;
            r_mode_q <= w_mode;
            r_tick   <= w_fire;
            if (w_reload) begin
                r_cnt <= hp_m1(w_lvl_next);
            end else if (r_cnt == '0) begin
                r_cnt <= hp_m1(r_lvl);
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_mode != r_mode_q) begin
                r_phase <= 1'b1;
                r_chase <= N_LIGHTS'(1);
            end else if (w_fire) begin
                if (r_mode_q == M_BLINK) begin
                    r_phase <= ~r_phase;
                end
                if (r_mode_q == M_CHASE) begin
                    r_chase <= {r_chase[N_LIGHTS-2:0], r_chase[N_LIGHTS-1]};
                end
            end
        end
    end

    assign rate_level = LEVELS'(1) << r_lvl;
    assign tick       = r_tick;

    always_comb begin
        rear_light = '0;
        case (r_mode_q)
            M_OFF:    rear_light = '0;
            M_BLINK:  rear_light = {N_LIGHTS{r_phase}};
            M_CHASE:  rear_light = r_chase;
            M_STEADY: rear_light = '1;
            default:  rear_light = '0;
        endcase
    end
endmodule
